imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter AUTO_DEFAULT, default 0, giving the format-select mode loaded into the mode register at reset (0 = explicit op, 1 = opcode auto-decode).

Interface
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  instruction word offered.
REQ-006 in_ready  output  1  block can accept; registered, equals NOT skid_valid.
REQ-007 instr  input  32  instruction word.
REQ-008 op  input  3  explicit format: 000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal.
REQ-009 auto_mode  input  1  when high, format comes from instr[6:0] and op is ignored; sampled with each accepted word.
REQ-010 out_valid  output  1  imm/illegal valid.
REQ-011 out_ready  input  1  consumer accepts.
REQ-012 imm  output  XLEN  sign- or zero-extended immediate.
REQ-013 illegal  output  1  format unresolvable; imm is 0 when set.
REQ-014 illegal_cnt  output  8  saturating count of illegal results delivered.

Function
REQ-015 The block SHALL accept a word on any cycle where in_valid AND in_ready are both high.
REQ-016 Latency SHALL be one cycle: a word accepted at edge N with an empty output stage SHALL appear with out_valid high after edge N.
REQ-017 A result SHALL leave the block on any cycle where out_valid AND out_ready are both high.
REQ-018 Buffering SHALL be two entries: an output register plus a skid register.
- A result goes to the skid register only when it is accepted while the output register holds an unconsumed result.
- in_ready SHALL deassert the cycle after the skid register fills.
REQ-019 Results SHALL leave in acceptance order; skid contents move to the output register before any newer word.
REQ-020 On simultaneous accept and deliver with skid empty, the new result SHALL replace the output register and out_valid SHALL stay high.
REQ-021 The I format SHALL produce sext(instr[31:20]).
REQ-022 The S format SHALL produce sext({instr[31:25], instr[11:7]}).
REQ-023 The B format SHALL produce sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-024 The J format SHALL produce sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-025 The U format SHALL produce sext({instr[31:12], 12'b0}); at XLEN=64, bits 63:32 copy instr[31].
REQ-026 Sign extension SHALL replicate instr[31] to bit XLEN-1.
REQ-027 Auto-decode SHALL map instr[6:0] to formats as follows:
- 0010011, 0000011, 1100111, 1110011 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 1101111 -> J.
- 0110111, 0010111 -> U.
- Any other value -> illegal.
REQ-028 An illegal result SHALL carry imm = 0, illegal = 1, and SHALL still pass through the handshake like any other result.
REQ-029 illegal_cnt SHALL increment by 1 when an illegal result is delivered (out_valid AND out_ready), and SHALL saturate at 255.
REQ-030 Output and skid contents SHALL NOT change while held under backpressure.

Reset
REQ-031 While rst is high at a rising edge, the block SHALL clear out_valid, skid_valid, imm, illegal and illegal_cnt to 0, and SHALL drive in_ready to 1 after that edge.
REQ-032 Reset SHALL discard any buffered results, including mid-backpressure; no result accepted before reset SHALL appear afterward.
REQ-033 in_valid SHALL be ignored during a reset cycle.

Verification
REQ-034 Auto-decode, XLEN=32, out_ready=1, the block SHALL produce:
- 0xFFF00093 -> 0xFFFFFFFF.
- 0x00112623 -> 0x0000000C.
- 0xFE000EE3 -> 0xFFFFFFFC.
- 0x0010006F -> 0x00000800.
- 0x123450B7 -> 0x12345000.
- Each result arrives one cycle after acceptance.
REQ-035 XLEN=64, auto-decode: 0x800000B7 -> 0xFFFFFFFF80000000; 0x123450B7 -> 0x0000000012345000.
REQ-036 Explicit op=110 with any instr, and auto-decode with instr=0x0000007F, -> illegal=1, imm=0; illegal_cnt reaches 2 after both are delivered, and stays at 255 after 300 illegal deliveries.
REQ-037 Backpressure test, all the following SHALL hold:
- With out_ready=0, offer words A, B, C back-to-back.
- A and B are accepted; in_ready goes low; C is held.
- After out_ready rises, the outputs are A, B, C in order with no duplicates or drops.
- While stalled, imm holds A.
REQ-038 Reset test: with A in the output register and B in the skid register, asserting rst for one cycle SHALL give out_valid=0, in_ready=1, illegal_cnt=0, and neither A nor B SHALL be delivered afterward.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : RISC-V immediate generator with a valid/ready input, a one-cycle
//            output register and a skid register. Formats come from an
//            explicit op code or from auto-decode of the opcode field.
//            Illegal results carry imm = 0 and are counted when delivered.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter bit AUTO_DEFAULT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      op,
  input  logic            auto_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic [7:0]      illegal_cnt
);

  // Internal format codes; the explicit op input uses the same encoding.
  localparam logic [2:0] c_fmt_i   = 3'b000;
  localparam logic [2:0] c_fmt_s   = 3'b001;
  localparam logic [2:0] c_fmt_b   = 3'b010;
  localparam logic [2:0] c_fmt_j   = 3'b011;
  localparam logic [2:0] c_fmt_u   = 3'b100;
  localparam logic [2:0] c_fmt_bad = 3'b111;

  localparam logic [7:0] c_cnt_max = 8'hFF;

  // Pipeline state
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  logic            out_ill_q,   out_ill_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic            skid_ill_q,   skid_ill_d;
  logic            in_ready_q,  in_ready_d;
  logic [7:0]      cnt_q,       cnt_d;
  logic            mode_q,      mode_d;

  // Combinational datapath
  logic            accept;
  logic            deliver;
  logic            mode_sel;
  logic [2:0]      fmt;
  logic [31:0]     imm32;
  logic            new_ill;
  logic [XLEN-1:0] new_imm;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  // An offered word always carries its own mode; the register only supplies
  // the idle-time value (reset default, then the last accepted mode).
  assign mode_sel = in_valid ? auto_mode : mode_q;

  // Resolve the immediate format from op or from the opcode field.
  always_comb begin
    fmt = op;
    if (mode_sel) begin
      case (instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = c_fmt_i;
        7'b0100011:                                     fmt = c_fmt_s;
        7'b1100011:                                     fmt = c_fmt_b;
        7'b1101111:                                     fmt = c_fmt_j;
        7'b0110111, 7'b0010111:                         fmt = c_fmt_u;
        default:                                        fmt = c_fmt_bad;
      endcase
    end
  end

  // Assemble the 32-bit sign-extended immediate; bit 31 always equals
  // instr[31] for legal formats, so widening to 64 bits copies that bit.
  always_comb begin
    imm32   = 32'd0;
    new_ill = 1'b0;
    case (fmt)
      c_fmt_i: imm32 = {{20{instr[31]}}, instr[31:20]};
      c_fmt_s: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      c_fmt_b: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      c_fmt_j: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      c_fmt_u: imm32 = {instr[31:12], 12'd0};
      default: new_ill = 1'b1;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_xlen64
      assign new_imm = {{32{imm32[31]}}, imm32};
    end else begin : g_xlen32
      assign new_imm = imm32[XLEN-1:0];
    end
  endgenerate

  // Next-state for the output/skid pair, in_ready, mode and illegal counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_ill_d   = skid_ill_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;

    if (accept) begin
      mode_d = auto_mode;
    end

    if (!out_valid_q || deliver) begin
      // Output stage frees up: the older skid entry goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_imm_d = new_imm;
          skid_ill_d = new_ill;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_imm_d = new_imm;
          out_ill_d = new_ill;
        end
      end
    end else if (accept) begin
      // Output stage is held: park the new result in the skid register.
      skid_valid_d = 1'b1;
      skid_imm_d   = new_imm;
      skid_ill_d   = new_ill;
    end

    in_ready_d = ~skid_valid_d;

    if (deliver && out_ill_q && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers with synchronous reset; reset discards buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_ill_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= 8'd0;
      mode_q       <= AUTO_DEFAULT;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_ill_q   <= skid_ill_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign imm         = out_imm_q;
  assign illegal     = out_ill_q;
  assign illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Directed self-checking bench for imm_gen_pipe at XLEN 32 and 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  op;
  logic        auto_mode;
  logic        out_ready;

  logic        in_ready_32, out_valid_32, illegal_32;
  logic [31:0] imm_32;
  logic [7:0]  cnt_32;
  logic        in_ready_64, out_valid_64, illegal_64;
  logic [63:0] imm_64;
  logic [7:0]  cnt_64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DEFAULT(1'b0)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
    .instr(instr), .op(op), .auto_mode(auto_mode), .out_valid(out_valid_32),
    .out_ready(out_ready), .imm(imm_32), .illegal(illegal_32),
    .illegal_cnt(cnt_32)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DEFAULT(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
    .instr(instr), .op(op), .auto_mode(auto_mode), .out_valid(out_valid_64),
    .out_ready(out_ready), .imm(imm_64), .illegal(illegal_64),
    .illegal_cnt(cnt_64)
  );

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] auto_in  [5] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3,
                                32'h0010006F, 32'h123450B7};
  logic [31:0] auto_exp [5] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC,
                                32'h00000800, 32'h12345000};

  // Explicit-op vectors chosen so the opcode field disagrees with op.
  logic [31:0] ex_in  [4] = '{32'h123450B7, 32'hFFF00093, 32'h00112623,
                              32'h80000013};
  logic [2:0]  ex_op  [4] = '{3'b000, 3'b100, 3'b001, 3'b000};
  logic [31:0] ex_exp [4] = '{32'h00000123, 32'hFFF00000, 32'h0000000C,
                              32'hFFFFF800};

  initial begin
    rst = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; op = 3'b000;
    auto_mode = 1'b1; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid_32}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready_32},  64'd1);
    chk("rst_imm",       {32'd0, imm_32},       64'd0);
    chk("rst_illegal",   {63'd0, illegal_32},   64'd0);
    chk("rst_cnt",       {56'd0, cnt_32},       64'd0);

    // Auto-decode, streaming one word per cycle with out_ready high
    in_valid = 1'b1; auto_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr = auto_in[i];
      tick();
      chk("auto_valid", {63'd0, out_valid_32}, 64'd1);
      chk("auto_imm",   {32'd0, imm_32},       {32'd0, auto_exp[i]});
    end
    in_valid = 1'b0;
    tick();
    chk("auto_drain", {63'd0, out_valid_32}, 64'd0);

    // XLEN=64 U-format extension
    in_valid = 1'b1;
    instr = 32'h800000B7; tick();
    chk("x64_neg", imm_64, 64'hFFFFFFFF80000000);
    instr = 32'h123450B7; tick();
    chk("x64_pos", imm_64, 64'h0000000012345000);

    // Explicit op with mismatched opcodes
    auto_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr = ex_in[i]; op = ex_op[i];
      tick();
      chk("ex_imm", {32'd0, imm_32}, {32'd0, ex_exp[i]});
      chk("ex_ill", {63'd0, illegal_32}, 64'd0);
    end

    // Illegal results: explicit op=110, then auto-decode of 0x7F
    op = 3'b110; instr = 32'h12345013; tick();
    chk("ill_op_flag", {63'd0, illegal_32}, 64'd1);
    chk("ill_op_imm",  {32'd0, imm_32},     64'd0);
    auto_mode = 1'b1; instr = 32'h0000007F; tick();
    chk("ill_auto_flag", {63'd0, illegal_32}, 64'd1);
    chk("ill_auto_imm",  {32'd0, imm_32},     64'd0);
    in_valid = 1'b0; tick();
    chk("ill_cnt2", {56'd0, cnt_32}, 64'd2);

    // Saturation: 300 further illegal deliveries
    in_valid = 1'b1; auto_mode = 1'b0; op = 3'b111;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100) chk("ill_cnt101", {56'd0, cnt_32}, 64'd101);
    end
    in_valid = 1'b0; tick(); tick();
    chk("ill_cnt_sat", {56'd0, cnt_32}, 64'd255);

    // Backpressure: A, B accepted, C held, then A, B, C in order
    auto_mode = 1'b1; op = 3'b000; out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'hFFF00093; tick();
    chk("bp_a_imm",   {32'd0, imm_32},      64'hFFFFFFFF);
    chk("bp_a_ready", {63'd0, in_ready_32}, 64'd1);
    instr = 32'h00112623; tick();
    chk("bp_b_ready", {63'd0, in_ready_32}, 64'd0);
    chk("bp_b_hold",  {32'd0, imm_32},      64'hFFFFFFFF);
    instr = 32'h123450B7; tick(); tick();
    chk("bp_c_ready", {63'd0, in_ready_32}, 64'd0);
    chk("bp_c_hold",  {32'd0, imm_32},      64'hFFFFFFFF);
    chk("bp_c_valid", {63'd0, out_valid_32}, 64'd1);
    out_ready = 1'b1; tick();
    chk("bp_out_b",   {32'd0, imm_32},      64'h0000000C);
    chk("bp_ready_b", {63'd0, in_ready_32}, 64'd1);
    tick();
    chk("bp_out_c",   {32'd0, imm_32},      64'h12345000);
    chk("bp_valid_c", {63'd0, out_valid_32}, 64'd1);
    in_valid = 1'b0; tick();
    chk("bp_nodup",   {63'd0, out_valid_32}, 64'd0);

    // Reset with A in output and B in skid; C offered during reset is dropped
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'hFFF00093; tick();
    instr = 32'h00112623; tick();
    chk("rs_pre_skid", {63'd0, in_ready_32}, 64'd0);
    rst = 1'b1; instr = 32'h123450B7; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rs_valid", {63'd0, out_valid_32}, 64'd0);
    chk("rs_ready", {63'd0, in_ready_32},  64'd1);
    chk("rs_cnt",   {56'd0, cnt_32},       64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_no_stale", {63'd0, out_valid_32}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
